demux_4_32_reg: RTL and testbench
=================================

Name: demux_4_32_reg

Overview:
- Registered 1-to-4 demultiplexer: the distributing counterpart of the 4:1 32-bit result mux.
- Takes one valid/ready input stream with a 2-bit select and routes each beat into one of four independent one-entry output slots.
- Each slot has its own valid/ready handshake.
- Used in the P4 datapath to steer a single producer (e.g. memory/ALU response) to one of four consumers without combinational paths from output ready to input data.

Parameters:
- WIDTH, 32, data width of input and each output.
- CNT_W, 16, width of per-port beat counters (only used with optional feature).

Ports:
- clk  input  1  single clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all output slots.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted this cycle when in_valid & in_ready.
- in_sel  input  2  destination port 0..3 for current input beat.
- in_data  input  WIDTH  input payload.
- out_valid  output  4  bit i: slot i holds a beat.
- out_ready  input  4  bit i: consumer i takes slot i's beat this cycle.
- out_data0  output  WIDTH  slot 0 payload.
- out_data1  output  WIDTH  slot 1 payload.
- out_data2  output  WIDTH  slot 2 payload.
- out_data3  output  WIDTH  slot 3 payload.
- beat_cnt  output  4*CNT_W  per-port accepted-beat counters, port i in bits [i*CNT_W +: CNT_W]. Present only with DEMUX_BEAT_CNT_EN.

Behaviour:
- Reset (resetn=0, async): out_valid=4'b0000, all out_dataN=0, beat_cnt=0. in_ready is 0 while in reset. Reset mid-transfer discards all held beats.
- Slot state per port: EMPTY / FULL.
  - EMPTY→FULL on accept to that port.
  - FULL→EMPTY on out_ready[i] with no new accept to i.
  - FULL→FULL (data replaced) on simultaneous drain and accept to i.
- in_ready = ~flush & (~out_valid[in_sel] | out_ready[in_sel]) — combinational from in_sel, out_valid and out_ready only, never from in_data.
- Accept: in_valid & in_ready. Next cycle out_valid[in_sel]=1 and out_data[in_sel]=in_data. Latency 1 cycle; throughput 1 beat/cycle per port with continuous out_ready.
- Non-selected slots are unaffected by an accept. A stalled slot blocks only beats addressed to it.
- Holding rule: while out_valid[i] & ~out_ready[i], out_data_i stays stable. The upstream must hold in_data/in_sel stable while in_valid & ~in_ready. The bench checks this; the RTL does not enforce it.
- out_dataN keeps its last value after drain; it is don't-care when out_valid[N]=0.
- flush=1: at the next edge all out_valid clear; no accept occurs that cycle (in_ready=0); counters are not cleared. Flush while resetn=0 has no effect.
- Simultaneous out_ready on multiple ports drains each independently in the same cycle.
- out_ready[i]=1 with out_valid[i]=0 is ignored.

Optional Feature:
- Macro DEMUX_BEAT_CNT_EN.
- Defined: beat_cnt port exists. Counter i increments by 1 on every accept with in_sel=i. Wraps modulo 2^CNT_W (0xFFFF→0x0000 for the default). Cleared only by resetn.
- Undefined: no beat_cnt port, no counter flops; all other behaviour is identical.

Decomposition:
- Shared package demux_pkg: SEL_W=2, NPORTS=4, localparams PORT0..PORT3, default WIDTH and CNT_W.
- Sub-module demux_slot: one-entry register slice with valid/ready, load, drain and flush, instantiated 4×.
- Top level holds in_ready decode, one-hot load generation and optional counters.

Test Plan:
- Reset then single beat: in_sel=2, in_data=0xDEADBEEF, all out_ready=0 → next cycle out_valid=4'b0100, out_data2=0xDEADBEEF; in_ready for sel=2 drops to 0.
- Back-to-back same port with out_ready[1]=1: data 0x1,0x2,0x3 on sel=1 over 3 cycles → out_data1 shows 0x1,0x2,0x3 on consecutive cycles, in_ready stays 1.
- Stalled port isolation: slot 0 full with out_ready[0]=0; send sel=3 data 0xA5A5A5A5 → accepted, out_valid=4'b1001; a sel=0 beat sees in_ready=0 until out_ready[0]=1.
- Flush with pending accept: slots 0 and 2 full, in_valid=1 sel=1, flush=1 → in_ready=0, next cycle out_valid=4'b0000, slot 1 stays empty.
- Async reset mid-operation: drop resetn between clock edges with out_valid=4'b1111 → out_valid=0 immediately, without waiting for a clock edge.
- With DEMUX_BEAT_CNT_EN: 0x10000 accepts to port 3 plus 5 to port 0 → beat_cnt port3=0x0000 (wrapped), port0=0x0005; flush leaves counts intact.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-4 demultiplexer.
// Optional per-port beat counters are enabled with DEMUX_BEAT_CNT_EN.
package demux_pkg;

    localparam int unsigned SEL_W         = 2;
    localparam int unsigned NPORTS        = 4;
    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_CNT_W = 16;

    localparam logic [SEL_W-1:0] PORT0 = 2'd0;
    localparam logic [SEL_W-1:0] PORT1 = 2'd1;
    localparam logic [SEL_W-1:0] PORT2 = 2'd2;
    localparam logic [SEL_W-1:0] PORT3 = 2'd3;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Destination select to one-hot port vector.
    function automatic logic [NPORTS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        return NPORTS'(1) << sel;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register slice with valid/ready, load, drain and flush.
// A load in the same cycle as a drain replaces the held beat.
module demux_slot
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    slot_state_e state_q;
    slot_state_e state_d;

    // Slot occupancy register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush wins; otherwise a load fills, a drain without a load empties.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = SLOT_EMPTY;
        end else if (load) begin
            state_d = SLOT_FULL;
        end else if ((state_q == SLOT_FULL) && ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    // Payload only moves on a load, so it is stable while the slot stalls.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data <= '0;
        end else if (load && !flush) begin
            data <= load_data;
        end
    end

    assign valid = (state_q == SLOT_FULL);

endmodule

// File: rtl/demux_4_32_reg.sv
// Registered 1-to-4 demultiplexer: one valid/ready input steered into four slots.
// Define DEMUX_BEAT_CNT_EN to add the beat_cnt per-port accept counters.
module demux_4_32_reg
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic [WIDTH-1:0]     in_data,
    output logic [NPORTS-1:0]    out_valid,
    input  logic [NPORTS-1:0]    out_ready,
    output logic [WIDTH-1:0]     out_data0,
    output logic [WIDTH-1:0]     out_data1,
    output logic [WIDTH-1:0]     out_data2,
    output logic [WIDTH-1:0]     out_data3
`ifdef DEMUX_BEAT_CNT_EN
    ,
    output logic [NPORTS*CNT_W-1:0] beat_cnt
`endif
);

    if (WIDTH == 0 || CNT_W == 0) begin : g_bad_cfg
        $error("demux_4_32_reg: WIDTH and CNT_W must be nonzero");
    end

    logic [NPORTS-1:0] sel_hot;
    logic [NPORTS-1:0] load;
    logic [WIDTH-1:0]  slot_data [NPORTS];

    // Ready depends only on the addressed slot, never on the payload.
    assign sel_hot  = sel_onehot(in_sel);
    assign in_ready = resetn & ~flush & (~out_valid[in_sel] | out_ready[in_sel]);
    assign load     = (in_valid && in_ready) ? sel_hot : '0;

    for (genvar i = 0; i < NPORTS; i++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .resetn   (resetn),
            .flush    (flush),
            .load     (load[i]),
            .load_data(in_data),
            .ready    (out_ready[i]),
            .valid    (out_valid[i]),
            .data     (slot_data[i])
        );
    end

    assign out_data0 = slot_data[PORT0];
    assign out_data1 = slot_data[PORT1];
    assign out_data2 = slot_data[PORT2];
    assign out_data3 = slot_data[PORT3];

`ifdef DEMUX_BEAT_CNT_EN
    // Wrapping accept counters, cleared only by reset (flush leaves them).
    for (genvar i = 0; i < NPORTS; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                cnt_q <= '0;
            end else if (load[i]) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        assign beat_cnt[i*CNT_W +: CNT_W] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_demux_4_32_reg.sv
// Scoreboard bench for demux_4_32_reg; counter checks need DEMUX_BEAT_CNT_EN.
module tb_demux_4_32_reg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 16;

    logic              clk       = 1'b0;
    logic              resetn    = 1'b0;
    logic              flush     = 1'b0;
    logic              in_valid  = 1'b0;
    logic [1:0]        in_sel    = 2'd0;
    logic [WIDTH-1:0]  in_data   = '0;
    logic              in_ready;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready = 4'b0000;
    logic [WIDTH-1:0]  out_data0, out_data1, out_data2, out_data3;
`ifdef DEMUX_BEAT_CNT_EN
    logic [4*CNT_W-1:0] beat_cnt;
`endif

    logic [WIDTH-1:0] od [4];
    logic [WIDTH-1:0] exp_q [4][$];
    int n_tests = 0;
    int n_fail  = 0;
    int w;

    always #5 clk = ~clk;

    demux_4_32_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data0(out_data0),
        .out_data1(out_data1),
        .out_data2(out_data2),
        .out_data3(out_data3)
`ifdef DEMUX_BEAT_CNT_EN
        ,
        .beat_cnt (beat_cnt)
`endif
    );

    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic clear_q();
        for (int i = 0; i < 4; i++) exp_q[i].delete();
    endtask

    // Drive one beat; wait (bounded) for in_ready, record expectation, step one edge.
    task automatic send(input logic [1:0] sel, input logic [WIDTH-1:0] data, output int waits);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        waits    = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 50) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: port %0d got no in_ready, required 1", sel);
                break;
            end
            @(posedge clk); #1;
        end
        if (in_ready) exp_q[sel].push_back(data);
        @(posedge clk); #1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Monitor: a drained slot must match the oldest expectation; a stalled slot must hold it.
    always @(negedge clk) begin
        if (resetn) begin
            for (int i = 0; i < 4; i++) begin
                if (out_valid[i]) begin
                    if (exp_q[i].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_valid: port %0d valid with data %0h, required no beat", i, od[i]);
                    end else if (out_ready[i]) begin
                        check($sformatf("drain_p%0d", i), 64'(od[i]), 64'(exp_q[i].pop_front()));
                    end else begin
                        check($sformatf("hold_p%0d", i), 64'(od[i]), 64'(exp_q[i][0]));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with a beat offered to show in_ready is held low.
        in_valid = 1'b1;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h0);
        check("rst_data0", 64'(out_data0), 64'h0);
        check("rst_data3", 64'(out_data3), 64'h0);
        step();
        resetn   = 1'b1;
        in_valid = 1'b0;
        step();

        // Single beat to port 2.
        send(2'd2, 32'hDEADBEEF, w);
        check("t1_wait", 64'(w), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_out_valid", 64'(out_valid), 64'h4);
        check("t1_data2", 64'(out_data2), 64'hDEADBEEF);
        check("t1_in_ready_full", 64'(in_ready), 64'h0);
        step();
        out_ready = 4'b0100;
        step();
        out_ready = 4'b0000;
        @(negedge clk);
        check("t1_drained", 64'(out_valid), 64'h0);

        // Back-to-back on port 1 with continuous out_ready.
        step();
        out_ready = 4'b0010;
        for (int k = 1; k <= 3; k++) begin
            send(2'd1, 32'(k), w);
            check("t2_wait", 64'(w), 64'd0);
        end
        in_valid = 1'b0;
        step();
        out_ready = 4'b0000;
        @(negedge clk);
        check("t2_empty", 64'(out_valid), 64'h0);

        // Stalled port 0 does not block port 3.
        step();
        send(2'd0, 32'h11, w);
        check("t3_wait0", 64'(w), 64'd0);
        send(2'd3, 32'hA5A5A5A5, w);
        check("t3_wait3", 64'(w), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        check("t3_out_valid", 64'(out_valid), 64'h9);
        step();
        in_valid = 1'b1;
        in_sel   = 2'd0;
        in_data  = 32'h22;
        repeat (2) begin
            @(negedge clk);
            check("t3_blocked", 64'(in_ready), 64'h0);
            step();
        end
        out_ready = 4'b0001;
        send(2'd0, 32'h22, w);
        check("t3_unblock_wait", 64'(w), 64'd0);
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        @(negedge clk);
        check("t3_refill", 64'(out_valid), 64'h9);
        check("t3_data0", 64'(out_data0), 64'h22);
        step();
        out_ready = 4'b1001;
        step();
        out_ready = 4'b0000;
        @(negedge clk);
        check("t3_empty", 64'(out_valid), 64'h0);

        // Flush with a pending accept to port 1.
        step();
        send(2'd0, 32'h33, w);
        send(2'd2, 32'h44, w);
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_pre", 64'(out_valid), 64'h5);
        step();
        in_valid = 1'b1;
        in_sel   = 2'd1;
        in_data  = 32'h55;
        flush    = 1'b1;
        @(negedge clk);
        check("t4_in_ready", 64'(in_ready), 64'h0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        clear_q();
        @(negedge clk);
        check("t4_flushed", 64'(out_valid), 64'h0);

        // All four drain together; ready on empty slots is ignored.
        step();
        for (int k = 0; k < 4; k++) send(2'(k), 32'h100 + 32'(k), w);
        in_valid = 1'b0;
        @(negedge clk);
        check("t5_full", 64'(out_valid), 64'hF);
        step();
        out_ready = 4'b1111;
        step();
        @(negedge clk);
        check("t5_drained", 64'(out_valid), 64'h0);
        step();
        out_ready = 4'b0000;

        // Asynchronous reset between edges with every slot full.
        for (int k = 0; k < 4; k++) send(2'(k), 32'h200 + 32'(k), w);
        in_valid = 1'b0;
        @(negedge clk);
        check("t6_full", 64'(out_valid), 64'hF);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("t6_async_valid", 64'(out_valid), 64'h0);
        check("t6_async_data1", 64'(out_data1), 64'h0);
        check("t6_async_in_ready", 64'(in_ready), 64'h0);
        clear_q();
        step();
        resetn = 1'b1;
        step();

`ifdef DEMUX_BEAT_CNT_EN
        // 0x10000 beats to port 3 wrap its counter; 5 to port 0.
        out_ready = 4'b1000;
        for (int k = 0; k < 32'h10000; k++) send(2'd3, 32'(k), w);
        out_ready = 4'b1001;
        for (int k = 0; k < 5; k++) send(2'd0, 32'h300 + 32'(k), w);
        in_valid = 1'b0;
        step();
        out_ready = 4'b0000;
        @(negedge clk);
        check("cnt_p3_wrap", 64'(beat_cnt[3*CNT_W +: CNT_W]), 64'h0);
        check("cnt_p0", 64'(beat_cnt[0 +: CNT_W]), 64'h5);
        check("cnt_p1", 64'(beat_cnt[1*CNT_W +: CNT_W]), 64'h0);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        check("cnt_p0_after_flush", 64'(beat_cnt[0 +: CNT_W]), 64'h5);
`endif

        for (int i = 0; i < 4; i++) check($sformatf("q_empty_p%0d", i), 64'(exp_q[i].size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
